hbm_axi_responder: RTL and testbench



---
 rtl/hbm_axi_responder.sv | 205 ++++++++++++++++++++
 tb/tb_hbm_axi_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_axi_responder.sv
// AXI4 INCR-burst memory responder standing in for one HBM pseudo-channel.
// Read and write paths are independent FSMs sharing a byte-writable word array.
module hbm_axi_responder #(
  parameter int DWIDTH    = 512,
  parameter int AWIDTH    = 33,
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AWIDTH-1:0]      araddr,
  input  logic [7:0]             arlen,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [DWIDTH-1:0]      rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [AWIDTH-1:0]      awaddr,
  input  logic [7:0]             awlen,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DWIDTH-1:0]      wdata,
  input  logic [DWIDTH/8-1:0]    wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready
);
  localparam int BPB  = DWIDTH / 8;
  localparam int OFFW = $clog2(BPB);
  localparam int IDXW = AWIDTH - OFFW;
  localparam int MW   = $clog2(MEM_DEPTH);
  localparam int CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [DWIDTH-1:0] mem [MEM_DEPTH];

  rstate_t           rstate;
  logic [IDXW-1:0]   ridx;
  logic [7:0]        rlen;
  logic [7:0]        rbeat;
  logic [CW-1:0]     rcnt;

  wstate_t           wstate;
  logic [IDXW-1:0]   widx;
  logic [7:0]        wlen;
  logic [7:0]        wbeat;
  logic              werr;

  logic [IDXW-1:0]   ar_idx;
  logic [IDXW-1:0]   aw_idx;
  logic [IDXW-1:0]   rnext_idx;
  logic              whs;
  logic              beat_err;
  logic              unused;

  assign ar_idx    = araddr[AWIDTH-1:OFFW];
  assign aw_idx    = awaddr[AWIDTH-1:OFFW];
  assign rnext_idx = ridx + IDXW'(1);
  assign whs       = wvalid && wready;
  assign unused    = ^{araddr[OFFW-1:0], awaddr[OFFW-1:0]};

  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return idx < IDXW'(MEM_DEPTH);
  endfunction

  function automatic logic [DWIDTH-1:0] rd_word(input logic [IDXW-1:0] idx);
    return in_range(idx) ? mem[idx[MW-1:0]] : '0;
  endfunction

  function automatic logic [1:0] rd_resp(input logic [IDXW-1:0] idx);
    return in_range(idx) ? 2'b00 : 2'b10;
  endfunction

  // A beat is in error if it falls outside the array or breaks the announced length.
  assign beat_err = (wlast && (wbeat != wlen)) || (!wlast && (wbeat == wlen)) || !in_range(widx);

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            arready <= 1'b0;
            ridx    <= ar_idx;
            rlen    <= arlen;
            rbeat   <= 8'd0;
            rcnt    <= '0;
            if (RD_LAT == 0) begin
              rdata  <= rd_word(ar_idx);
              rresp  <= rd_resp(ar_idx);
              rvalid <= 1'b1;
              rlast  <= (arlen == 8'd0);
              rstate <= R_BURST;
            end else begin
              rstate <= R_WAIT;
            end
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rcnt == CW'(RD_LAT - 1)) begin
            rdata  <= rd_word(ridx);
            rresp  <= rd_resp(ridx);
            rvalid <= 1'b1;
            rlast  <= (rlen == 8'd0);
            rstate <= R_BURST;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
        R_BURST: begin
          // Outputs are only updated on a handshake, so they hold through stalls.
          if (rready) begin
            if (rbeat == rlen) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              ridx  <= rnext_idx;
              rbeat <= rbeat + 8'd1;
              rdata <= rd_word(rnext_idx);
              rresp <= rd_resp(rnext_idx);
              rlast <= ((rbeat + 8'd1) == rlen);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      werr    <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            widx    <= aw_idx;
            wlen    <= awlen;
            wbeat   <= 8'd0;
            werr    <= 1'b0;
            wstate  <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (whs) begin
            widx  <= widx + IDXW'(1);
            wbeat <= wbeat + 8'd1;
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (werr || beat_err) ? 2'b10 : 2'b00;
              wstate <= W_RESP;
            end else begin
              werr <= werr || beat_err;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            werr    <= 1'b0;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Array is never reset; writes are suppressed while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && wstate == W_DATA && whs && in_range(widx)) begin
      for (int i = 0; i < BPB; i++) begin
        if (wstrb[i]) mem[widx[MW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_hbm_axi_responder.sv
// Directed plus randomized bench for hbm_axi_responder against a word-level
// memory model built from the burst, strobe and response rules.
module tb_hbm_axi_responder;
  localparam int DW    = 512;
  localparam int AW    = 33;
  localparam int DEPTH = 1024;
  localparam int RDL   = 2;
  localparam int BPB   = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [BPB-1:0] wstrb;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] mdl [int];

  always #5 clk = ~clk;

  hbm_axi_responder #(.DWIDTH(DW), .AWIDTH(AW), .MEM_DEPTH(DEPTH), .RD_LAT(RDL)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [DW-1:0] mdl_rd(input int idx);
    if (idx >= DEPTH) return '0;
    if (mdl.exists(idx)) return mdl[idx];
    return '0;
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input int len, input int nbeats,
                          input logic [DW-1:0] d[$], input logic [BPB-1:0] s[$], input bit gaps);
    int base;
    int idx;
    int t;
    bit err;
    logic [DW-1:0] w;
    base = int'(addr >> 6);
    err  = (nbeats != len + 1);
    for (int b = 0; b < nbeats; b++) begin
      idx = base + b;
      if (idx < DEPTH) begin
        w = mdl_rd(idx);
        for (int k = 0; k < BPB; k++) if (s[b][k]) w[k*8 +: 8] = d[b][k*8 +: 8];
        mdl[idx] = w;
      end else begin
        err = 1'b1;
      end
    end
    t = 0;
    while (!awready && t < 50) begin tick(); t++; end
    chk_n("aw_ready_wait", int'(awready), 1);
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk_n("aw_then_wready", int'(wready), 1);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        tick();
        chk_n("w_gap_bvalid", int'(bvalid), 0);
      end
      wvalid = 1'b1; wdata = d[b]; wstrb = s[b]; wlast = (b == nbeats - 1);
      chk_n("w_wready", int'(wready), 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk_n("b_valid", int'(bvalid), 1);
    chk_n("b_resp", int'(bresp), err ? 2 : 0);
    chk_n("b_wready_low", int'(wready), 0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk_n("b_hold", int'(bvalid), 1);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk_n("b_cleared", int'(bvalid), 0);
    chk_n("b_awready", int'(awready), 1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
    int base;
    int idx;
    int beat;
    int cyc;
    int t;
    bit ph;
    bit hs;
    base = int'(addr >> 6);
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    chk_n("ar_ready_wait", int'(arready), 1);
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk_n("ar_busy", int'(arready), 0);
    repeat (RDL) begin
      chk_n("r_latency_idle", int'(rvalid), 0);
      tick();
    end
    beat = 0; cyc = 0; ph = 1'b0;
    while (beat <= len && cyc < 200) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      idx = base + beat;
      chk_n("r_valid", int'(rvalid), 1);
      if (!rvalid) break;
      chk("r_data", rdata, mdl_rd(idx));
      chk_n("r_resp", int'(rresp), (idx < DEPTH) ? 0 : 2);
      chk_n("r_last", int'(rlast), (beat == len) ? 1 : 0);
      hs = rready;
      tick();
      if (hs) beat++;
      cyc++;
    end
    rready = 1'b0;
    chk_n("r_beats", beat, len + 1);
    chk_n("r_end_valid", int'(rvalid), 0);
    chk_n("r_end_arready", int'(arready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]  dq[$];
    logic [BPB-1:0] sq[$];
    logic [AW-1:0]  a;
    int idx, len, nb, hcnt, t;

    rst = 1'b1;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    chk_n("rst_arready", int'(arready), 0);
    chk_n("rst_awready", int'(awready), 0);
    chk_n("rst_wready", int'(wready), 0);
    chk_n("rst_rvalid", int'(rvalid), 0);
    chk_n("rst_rlast", int'(rlast), 0);
    chk("rst_rdata", rdata, '0);
    chk_n("rst_rresp", int'(rresp), 0);
    chk_n("rst_bvalid", int'(bvalid), 0);
    chk_n("rst_bresp", int'(bresp), 0);
    rst = 1'b0;
    tick();
    chk_n("post_rst_arready", int'(arready), 1);
    chk_n("post_rst_awready", int'(awready), 1);

    // Basic 4-beat write then read back
    dq.delete(); sq.delete();
    for (int i = 1; i <= 4; i++) begin dq.push_back(DW'(i)); sq.push_back('1); end
    do_write(33'h0, 3, 4, dq, sq, 1'b0);
    do_read(33'h0, 3, 0);

    // Partial strobe
    dq.delete(); sq.delete();
    dq.push_back('1); sq.push_back('1);
    do_write(33'h40, 0, 1, dq, sq, 1'b0);
    dq.delete(); sq.delete();
    dq.push_back(DW'(8'hAA)); sq.push_back(BPB'(1));
    do_write(33'h40, 0, 1, dq, sq, 1'b0);
    chk("strobe_model", mdl_rd(1), {{(DW-8){1'b1}}, 8'hAA});
    do_read(33'h40, 0, 0);

    // Backpressure on an 8-beat read
    dq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) begin dq.push_back(rnd_word()); sq.push_back('1); end
    do_write(33'h100, 7, 8, dq, sq, 1'b1);
    do_read(33'h100, 7, 1);

    // Out of range read and write; index 0 must stay intact
    do_read(33'(DEPTH * 64), 0, 0);
    dq.delete(); sq.delete();
    dq.push_back(rnd_word()); sq.push_back('1);
    do_write(33'(DEPTH * 64), 0, 1, dq, sq, 1'b0);
    do_read(33'h0, 0, 0);

    // Short burst: awlen=3 but wlast on beat 2
    dq.delete(); sq.delete();
    for (int i = 0; i < 2; i++) begin dq.push_back(rnd_word()); sq.push_back('1); end
    do_write(33'h200, 3, 2, dq, sq, 1'b0);
    do_read(33'h200, 1, 0);

    // Burst straddling the top of the array
    dq.delete(); sq.delete();
    for (int i = 0; i < 4; i++) begin dq.push_back(rnd_word()); sq.push_back('1); end
    do_write(33'((DEPTH - 2) * 64), 3, 4, dq, sq, 1'b0);
    do_read(33'((DEPTH - 2) * 64), 3, 2);

    // Reset in the middle of a read burst
    dq.delete(); sq.delete();
    for (int i = 0; i < 4; i++) begin dq.push_back(rnd_word()); sq.push_back('1); end
    do_write(33'h300, 3, 4, dq, sq, 1'b0);
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    araddr = 33'h300; arlen = 8'd3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    hcnt = 0; t = 0;
    while (hcnt < 2 && t < 50) begin
      if (rvalid) hcnt++;
      tick();
      t++;
    end
    chk_n("mid_rst_beats", hcnt, 2);
    rst = 1'b1; rready = 1'b0;
    tick();
    chk_n("mid_rst_rvalid", int'(rvalid), 0);
    chk_n("mid_rst_arready", int'(arready), 0);
    rst = 1'b0;
    tick();
    chk_n("after_rst_arready", int'(arready), 1);
    chk_n("after_rst_awready", int'(awready), 1);
    do_read(33'h300, 3, 0);

    // Randomized mix of reads and writes
    for (int it = 0; it < 24; it++) begin
      idx = ($urandom_range(0, 3) == 0) ? DEPTH - 4 + $urandom_range(0, 3) : $urandom_range(0, 40);
      a   = (33'(idx) << 6) | 33'($urandom_range(0, 63));
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        nb = len + 1;
        if ($urandom_range(0, 4) == 0) nb = (len > 0 && $urandom_range(0, 1) == 1) ? len : len + 2;
        dq.delete(); sq.delete();
        for (int i = 0; i < nb; i++) begin
          dq.push_back(rnd_word());
          sq.push_back({$urandom(), $urandom()});
        end
        do_write(a, len, nb, dq, sq, 1'($urandom_range(0, 1)));
      end else begin
        do_read(a, len, $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
